// File: rtl/ififo_multi.sv
// Multi-lane instruction fetch FIFO: up to ENQ_W packets in and DEQ_W oldest packets out per cycle.
// Occupancy is held in an explicit counter; every output is a function of registered state only.
module ififo_multi #(
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned ENQ_W    = 4,
    parameter int unsigned DEQ_W    = 3,
    parameter int unsigned DATA_W   = 104,
    parameter int unsigned AF_SLACK = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic [ENQ_W-1:0]             in_valid,
    input  logic [ENQ_W*DATA_W-1:0]      in_data,
    output logic                         in_ready,
    output logic [DEQ_W-1:0]             out_valid,
    output logic [DEQ_W*DATA_W-1:0]      out_data,
    input  logic [$clog2(DEQ_W+1)-1:0]   deq_cnt,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         almost_full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);
    localparam int unsigned EQ_W  = $clog2(ENQ_W+1);
    localparam int unsigned DQ_W  = $clog2(DEQ_W+1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;

    logic [ENQ_W-1:0]  lane_take;
    logic [EQ_W-1:0]   n_enq;
    logic [EQ_W-1:0]   enq_eff;
    logic [DQ_W-1:0]   avail;
    logic [DQ_W-1:0]   n_deq;
    logic [CNT_W:0]    free_w;
    logic              run;

    // Only the leading run of valid lanes is taken; anything after the first gap is dropped.
    always_comb begin
        lane_take = '0;
        n_enq     = '0;
        run       = 1'b1;
        for (int unsigned i = 0; i < ENQ_W; i++) begin
            run          = run & in_valid[i];
            lane_take[i] = run;
            if (run)
                n_enq = EQ_W'(i + 1);
        end
    end

    always_comb begin
        free_w      = (CNT_W+1)'(DEPTH) - {1'b0, count};
        in_ready    = free_w >= (CNT_W+1)'(ENQ_W);
        almost_full = free_w <= (CNT_W+1)'(AF_SLACK);
        empty       = (count == '0);
        enq_eff     = in_ready ? n_enq : '0;
        avail       = (count >= CNT_W'(DEQ_W)) ? DQ_W'(DEQ_W) : DQ_W'(count);
        n_deq       = (deq_cnt < avail) ? deq_cnt : avail;
    end

    always_comb begin
        out_valid = '0;
        out_data  = '0;
        for (int unsigned i = 0; i < DEQ_W; i++) begin
            if (count > CNT_W'(i)) begin
                out_valid[i]                 = 1'b1;
                out_data[i*DATA_W +: DATA_W] = mem[rd_ptr + PTR_W'(i)];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(enq_eff);
            rd_ptr <= rd_ptr + PTR_W'(n_deq);
            count  <= count + CNT_W'(enq_eff) - CNT_W'(n_deq);
        end
    end

    // Storage is never cleared; stale entries stay hidden behind out_valid gating.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < ENQ_W; i++) begin
            if (in_ready && !flush && lane_take[i])
                mem[wr_ptr + PTR_W'(i)] <= in_data[i*DATA_W +: DATA_W];
        end
    end

endmodule

// File: tb/tb_ififo_multi.sv
// Scoreboard bench for ififo_multi: a queue model tracks accepted packets and is
// compared against the DUT outputs every cycle, plus targeted boundary checks.
module tb_ififo_multi;

    localparam int DEPTH  = 32;
    localparam int ENQ_W  = 4;
    localparam int DEQ_W  = 3;
    localparam int DATA_W = 104;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      flush;
    logic [ENQ_W-1:0]          in_valid;
    logic [ENQ_W*DATA_W-1:0]   in_data;
    logic                      in_ready;
    logic [DEQ_W-1:0]          out_valid;
    logic [DEQ_W*DATA_W-1:0]   out_data;
    logic [1:0]                deq_cnt;
    logic [5:0]                count;
    logic                      empty;
    logic                      almost_full;

    ififo_multi #(
        .DEPTH(DEPTH), .ENQ_W(ENQ_W), .DEQ_W(DEQ_W), .DATA_W(DATA_W), .AF_SLACK(8)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .deq_cnt(deq_cnt),
        .count(count), .empty(empty), .almost_full(almost_full)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [DATA_W-1:0] sb_q[$];
    logic [31:0] next_pc = 0;
    logic [31:0] seq_pc  = 0;
    int pops = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] mk(input logic [31:0] pc);
        return {pc, ~pc, pc ^ 32'hA5A5_A5A5, pc[7:0] ^ 8'h3C};
    endfunction

    task automatic check_outputs();
        int sz;
        logic [DEQ_W-1:0] ov;
        sz = sb_q.size();
        ov = '0;
        for (int j = 0; j < DEQ_W; j++) if (sz > j) ov[j] = 1'b1;
        check("count", 128'(count), 128'(sz));
        check("empty", 128'(empty), 128'(sz == 0));
        check("in_ready", 128'(in_ready), 128'((DEPTH - sz) >= ENQ_W));
        check("almost_full", 128'(almost_full), 128'((DEPTH - sz) <= 8));
        check("out_valid", 128'(out_valid), 128'(ov));
        for (int j = 0; j < DEQ_W; j++)
            check($sformatf("out_data%0d", j), 128'(out_data[j*DATA_W +: DATA_W]),
                  128'((j < sz) ? sb_q[j] : '0));
    endtask

    // Drive one cycle of stimulus, check the current state, update the model, then clock.
    task automatic step(input logic [3:0] v, input logic [1:0] d, input logic fl);
        int sz, ne, nd;
        logic rdy;
        in_valid = v;
        deq_cnt  = d;
        flush    = fl;
        for (int i = 0; i < ENQ_W; i++) in_data[i*DATA_W +: DATA_W] = mk(next_pc + 32'(4*i));
        check_outputs();
        sz  = sb_q.size();
        rdy = (DEPTH - sz) >= ENQ_W;
        ne  = 0;
        for (int i = 0; i < ENQ_W; i++) if (v[i] && ne == i) ne++;
        if (fl) begin
            sb_q.delete();
            next_pc = 0;
            seq_pc  = 0;
        end else begin
            nd = int'(d);
            if (nd > sz) nd = sz;
            if (nd > DEQ_W) nd = DEQ_W;
            for (int j = 0; j < nd; j++) begin
                check("seq_pc", 128'(out_data[j*DATA_W + 72 +: 32]), 128'(seq_pc));
                seq_pc += 4;
                pops++;
                void'(sb_q.pop_front());
            end
            if (rdy) begin
                for (int i = 0; i < ne; i++) begin
                    sb_q.push_back(mk(next_pc));
                    next_pc += 4;
                end
            end
        end
        @(posedge clk);
        #1;
        in_valid = '0;
        deq_cnt  = '0;
        flush    = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_count"}, 128'(count), 128'(0));
        check({tag, "_out_valid"}, 128'(out_valid), 128'(0));
        check({tag, "_out_data"}, 128'(out_data), 128'(0));
        check({tag, "_in_ready"}, 128'(in_ready), 128'(1));
        check({tag, "_empty"}, 128'(empty), 128'(1));
        check({tag, "_almost_full"}, 128'(almost_full), 128'(0));
    endtask

    initial begin
        logic [3:0] v;
        rst = 1'b0; flush = 1'b0; in_valid = '0; in_data = '0; deq_cnt = '0;
        #12;
        check_reset_state("por");
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;

        // Fill: 4 per cycle until full, then one refused attempt.
        for (int k = 0; k < 9; k++) begin
            step(4'b1111, 2'd0, 1'b0);
            if (k == 5) check("af_at_24", 128'(almost_full), 128'(1));
        end
        check("fill_count", 128'(count), 128'(32));
        check("fill_ready", 128'(in_ready), 128'(0));

        // Partial masks.
        step(4'b0000, 2'd0, 1'b1);
        step(4'b0111, 2'd0, 1'b0);
        check("mask0111", 128'(count), 128'(3));
        step(4'b1101, 2'd0, 1'b0);
        check("mask1101", 128'(count), 128'(4));
        check("lane2_pc", 128'(out_data[2*DATA_W + 72 +: 32]), 128'(8));

        // Simultaneous enqueue/dequeue around the full boundary.
        step(4'b0000, 2'd0, 1'b1);
        for (int k = 0; k < 7; k++) step(4'b1111, 2'd0, 1'b0);
        check("sim_pre", 128'(count), 128'(28));
        step(4'b1111, 2'd3, 1'b0);
        check("sim_28", 128'(count), 128'(29));
        step(4'b1111, 2'd3, 1'b0);
        check("sim_29", 128'(count), 128'(26));

        // Dequeue over-request clamps at the available count.
        step(4'b0000, 2'd0, 1'b1);
        step(4'b0001, 2'd0, 1'b0);
        step(4'b0000, 2'd3, 1'b0);
        check("clamp", 128'(count), 128'(0));
        step(4'b0000, 2'd3, 1'b0);
        check("clamp_empty", 128'(count), 128'(0));

        // Flush with concurrent enqueue and dequeue.
        for (int k = 0; k < 4; k++) step(4'b1111, 2'd0, 1'b0);
        step(4'b0001, 2'd0, 1'b0);
        check("pre_flush", 128'(count), 128'(17));
        step(4'b1111, 2'd2, 1'b1);
        check("flush_count", 128'(count), 128'(0));
        check("flush_valid", 128'(out_valid), 128'(0));
        check("flush_empty", 128'(empty), 128'(1));
        step(4'b0001, 2'd0, 1'b0);
        check("post_flush_lane0", 128'(out_data[0 +: DATA_W]), 128'(mk(0)));

        // Random stream of 100 sequential pcs across pointer wrap.
        step(4'b0000, 2'd0, 1'b1);
        pops = 0;
        for (int it = 0; it < 2000 && pops < 100; it++) begin
            v = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b1111;
            if (next_pc >= 400) v = 4'b0000;
            step(v, 2'($urandom_range(0, 3)), 1'b0);
        end
        check("stream_done", 128'(pops >= 100), 128'(1));

        // Asynchronous reset mid-stream with 10 entries held.
        step(4'b0000, 2'd0, 1'b1);
        step(4'b1111, 2'd0, 1'b0);
        step(4'b1111, 2'd0, 1'b0);
        step(4'b0011, 2'd0, 1'b0);
        check("pre_reset", 128'(count), 128'(10));
        #2 rst = 1'b0;
        #1 check_reset_state("async_rst");
        sb_q.delete(); next_pc = 0; seq_pc = 0;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        step(4'b0001, 2'd0, 1'b0);
        step(4'b0000, 2'd1, 1'b0);
        check_outputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
